button_event: RTL and testbench

Button gesture decoder placed directly downstream of the pin debouncer. It takes one debounced, active-low button level and turns it into single-cycle event pulses: press, release, click, double-click and long-press. Software or control FSMs use these pulses instead of polling raw levels. There is one instance per debounced button. The input must already be debounced and synchronous to `clk`.

---
 rtl/button_event.sv | 112 +++++++++++
 tb/tb_button_event.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/button_event.sv
// Gesture decoder for one debounced active-low button. It emits single-cycle
// press, release, click, double-click and long-press pulses.
module button_event #(
  parameter int LONG_PRESS_TIME   = 12000000,
  parameter int DOUBLE_CLICK_TIME = 3000000,
  parameter int CNT_WIDTH         = 24
) (
  input  logic clk,
  input  logic areset_n,
  input  logic btn_n,
  output logic pressed,
  output logic evt_press,
  output logic evt_release,
  output logic evt_click,
  output logic evt_double,
  output logic evt_long
);

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    WAIT2,
    PRESS2,
    LONG
  } state_t;

  localparam logic [CNT_WIDTH-1:0] LONG_LAST = CNT_WIDTH'(LONG_PRESS_TIME - 1);
  localparam logic [CNT_WIDTH-1:0] DBL_LAST  = CNT_WIDTH'(DOUBLE_CLICK_TIME - 1);

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 btn_q;
  logic                 fall;
  logic                 rise;

  assign fall    = btn_q & ~btn_n;
  assign rise    = ~btn_q & btn_n;
  assign pressed = ~btn_q;

  // An edge always takes priority over a timeout that lands in the same cycle.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      btn_q       <= 1'b1;
      evt_press   <= 1'b0;
      evt_release <= 1'b0;
      evt_click   <= 1'b0;
      evt_double  <= 1'b0;
      evt_long    <= 1'b0;
    end else begin
      btn_q       <= btn_n;
      evt_press   <= fall;
      evt_release <= rise;
      evt_click   <= 1'b0;
      evt_double  <= 1'b0;
      evt_long    <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (fall) state <= PRESS1;
        end
        PRESS1: begin
          if (rise) begin
            state <= WAIT2;
            cnt   <= '0;
          end else if (cnt == LONG_LAST) begin
            evt_long <= 1'b1;
            state    <= LONG;
            cnt      <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        WAIT2: begin
          if (fall) begin
            state <= PRESS2;
            cnt   <= '0;
          end else if (cnt == DBL_LAST) begin
            evt_click <= 1'b1;
            state     <= IDLE;
            cnt       <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        PRESS2: begin
          if (rise) begin
            evt_double <= 1'b1;
            state      <= IDLE;
            cnt        <= '0;
          end else if (cnt == LONG_LAST) begin
            evt_long <= 1'b1;
            state    <= LONG;
            cnt      <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        LONG: begin
          cnt <= '0;
          if (rise) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_event.sv
// Randomized scoreboard bench for button_event; a gesture-level model predicts
// pulses per clock edge, and a monitor compares them as the DUT produces them.
module tb_button_event;

  localparam int LPT = 100;
  localparam int DCT = 40;
  localparam int CW  = 8;

  logic clk = 1'b0;
  logic areset_n = 1'b0;
  logic btn_n = 1'b1;
  logic pressed, evt_press, evt_release, evt_click, evt_double, evt_long;

  button_event #(
    .LONG_PRESS_TIME(LPT),
    .DOUBLE_CLICK_TIME(DCT),
    .CNT_WIDTH(CW)
  ) dut (
    .clk(clk),
    .areset_n(areset_n),
    .btn_n(btn_n),
    .pressed(pressed),
    .evt_press(evt_press),
    .evt_release(evt_release),
    .evt_click(evt_click),
    .evt_double(evt_double),
    .evt_long(evt_long)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Event vector order: {press, release, click, double, long}
  typedef struct {
    int         stamp;
    logic [4:0] ev;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int failures = 0;

  logic m_prev = 1'b1;
  logic m_pend = 1'b0;
  logic m_second = 1'b0;
  logic m_long_done = 1'b0;
  int   m_p = 0;
  int   m_r = 0;
  logic exp_pressed = 1'b0;
  logic cur;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h at edge %0d", name, actual, expected, edge_cnt);
    end
  endtask

  // Gesture-level model: decides each edge's pulses from press/release times.
  task automatic modelStep(input int t, input logic b, input logic in_reset);
    logic [4:0] ev;
    logic fall, rise;
    ev = '0;
    if (in_reset) begin
      m_prev = 1'b1;
      m_pend = 1'b0;
      m_second = 1'b0;
      m_long_done = 1'b0;
      exp_pressed = 1'b0;
      return;
    end
    fall = m_prev && !b;
    rise = !m_prev && b;
    if (fall) begin
      ev[4] = 1'b1;
      m_second = m_pend && ((t - m_r) <= DCT);
      m_pend = 1'b0;
      m_p = t;
      m_long_done = 1'b0;
    end
    if (m_pend && (t - m_r) == DCT) begin
      ev[2] = 1'b1;
      m_pend = 1'b0;
    end
    if (rise) begin
      ev[3] = 1'b1;
      if (!m_long_done) begin
        if (m_second) begin
          ev[1] = 1'b1;
          m_second = 1'b0;
        end else begin
          m_pend = 1'b1;
          m_r = t;
        end
      end
    end
    if (!m_prev && !b && !m_long_done && (t - m_p) == LPT) begin
      ev[0] = 1'b1;
      m_long_done = 1'b1;
    end
    m_prev = b;
    exp_pressed = !b;
    if (ev != 5'b0) sb.push_back('{t, ev});
  endtask

  task automatic applyStimulus(input logic b, input int n);
    repeat (n) begin
      @(negedge clk);
      btn_n = b;
      modelStep(edge_cnt + 1, b, 1'b0);
    end
  endtask

  task automatic applyReset(input int n, input logic final_b);
    repeat (n) begin
      @(negedge clk);
      areset_n = 1'b0;
      btn_n = 1'($urandom_range(0, 1));
      modelStep(edge_cnt + 1, btn_n, 1'b1);
      #1;
      checkOutput("reset_outputs",
                  int'({pressed, evt_press, evt_release, evt_click, evt_double, evt_long}), 0);
    end
    @(negedge clk);
    areset_n = 1'b1;
    btn_n = final_b;
    modelStep(edge_cnt + 1, final_b, 1'b0);
  endtask

  // Monitor: compares whenever the DUT pulses or an expected pulse falls due.
  initial begin
    logic [4:0] dut_ev;
    int now;
    forever begin
      @(posedge clk);
      #1;
      now = edge_cnt;
      dut_ev = {evt_press, evt_release, evt_click, evt_double, evt_long};
      checkOutput("pressed", int'(pressed), int'(exp_pressed));
      while (sb.size() > 0 && sb[0].stamp < now) begin
        checkOutput("missed_event", 0, int'(sb[0].ev));
        void'(sb.pop_front());
      end
      if (sb.size() > 0 && sb[0].stamp == now) begin
        checkOutput("event_vector", int'(dut_ev), int'(sb[0].ev));
        void'(sb.pop_front());
      end else if (dut_ev != 5'b0) begin
        checkOutput("unexpected_event", int'(dut_ev), 0);
      end
    end
  end

  initial begin
    int len;
    int sel;
    applyReset(5, 1'b1);
    applyStimulus(1'b1, 5);
    // Single click, double click, long press
    applyStimulus(1'b0, 10); applyStimulus(1'b1, 60);
    applyStimulus(1'b0, 10); applyStimulus(1'b1, 20);
    applyStimulus(1'b0, 10); applyStimulus(1'b1, 60);
    applyStimulus(1'b0, 150); applyStimulus(1'b1, 60);
    // Long-press boundary: release exactly at the timeout edge, one before, one after
    applyStimulus(1'b0, LPT); applyStimulus(1'b1, 60);
    applyStimulus(1'b0, LPT - 1); applyStimulus(1'b1, 60);
    applyStimulus(1'b0, LPT + 1); applyStimulus(1'b1, 60);
    // Double-click window boundary: second press exactly at the timeout edge, then just late
    applyStimulus(1'b0, 10); applyStimulus(1'b1, DCT);
    applyStimulus(1'b0, 10); applyStimulus(1'b1, 60);
    applyStimulus(1'b0, 10); applyStimulus(1'b1, DCT + 1);
    applyStimulus(1'b0, 10); applyStimulus(1'b1, 60);
    // Second press held long: long pulse, no double
    applyStimulus(1'b0, 5); applyStimulus(1'b1, 10);
    applyStimulus(1'b0, 120); applyStimulus(1'b1, 60);
    // Reset during the double-click window, then a normal click
    applyStimulus(1'b0, 10); applyStimulus(1'b1, 15);
    applyReset(3, 1'b1);
    applyStimulus(1'b1, 60);
    applyStimulus(1'b0, 10); applyStimulus(1'b1, 60);
    // Button held while reset releases
    applyReset(2, 1'b0);
    applyStimulus(1'b0, 10); applyStimulus(1'b1, 60);

    cur = 1'b1;
    for (int i = 0; i < 200; i++) begin
      cur = !cur;
      sel = int'($urandom_range(0, 9));
      case (sel)
        0, 1, 2: len = int'($urandom_range(1, 15));
        3, 4:    len = int'($urandom_range(DCT - 2, DCT + 2));
        5, 6:    len = int'($urandom_range(LPT - 2, LPT + 2));
        7:       len = int'($urandom_range(120, 150));
        default: len = int'($urandom_range(16, 60));
      endcase
      if ($urandom_range(0, 24) == 0) applyReset(int'($urandom_range(1, 4)), cur);
      applyStimulus(cur, len);
    end

    applyStimulus(1'b1, 60);
    repeat (2) @(negedge clk);
    checkOutput("sb_drain", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
